// File: rtl/config_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : config_port_arbiter_pkg                                          |
// | Shared encodings for the configuration write-port arbiter: owner codes,    |
// | arbiter states and a small drop-tally helper.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package config_port_arbiter_pkg;

  // Owner codes double as priority rank: a lower non-zero code wins.
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_UART = 2'd1;
  localparam logic [1:0] OWNER_BB   = 2'd2;
  localparam logic [1:0] OWNER_CPU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_OWN    = 2'd2
  } arbState_t;

  // Number of words discarded in one cycle: lost strobes plus a flushed pend word.
  function automatic logic [2:0] dropTally(input logic [3:0] lost, input logic flush);
    logic [2:0] n;
    n = {2'b00, flush};
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, lost[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/config_port_arbiter_pend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : config_port_arbiter_pend                                         |
// | One-deep valid+data holding register. Load wins over flush so a word can   |
// | be consumed and replaced in the same cycle.                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module config_port_arbiter_pend #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_loadData,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Hold one pending word; a load replaces it, a flush (consume or discard) empties it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_loadData;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/config_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : config_port_arbiter                                              |
// | Session-based arbiter sharing the ConfigFSM write port between UART,       |
// | BitBang and CPU self-write. One owner at a time, FSM_Reset pulse on every  |
// | ownership change, 1-deep pending buffer, saturating drop counter.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module config_port_arbiter
  import config_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CPU_IDLE_CYCLES = 64,
  parameter int DROP_CNT_WIDTH  = 8
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      UartActive,
  input  logic [DATA_WIDTH-1:0]     UartWriteData,
  input  logic                      UartWriteStrobe,
  input  logic                      BBActive,
  input  logic [DATA_WIDTH-1:0]     BBWriteData,
  input  logic                      BBWriteStrobe,
  input  logic [DATA_WIDTH-1:0]     SelfWriteData,
  input  logic                      SelfWriteStrobe,
  output logic [DATA_WIDTH-1:0]     ConfigWriteData,
  output logic                      ConfigWriteStrobe,
  output logic                      FSM_Reset,
  output logic [1:0]                Owner,
  output logic                      Busy,
  output logic [DROP_CNT_WIDTH-1:0] DropCount
);

  localparam int IDLE_CNT_W = $clog2(CPU_IDLE_CYCLES + 1);
  localparam int DROP_SUM_W = DROP_CNT_WIDTH + 3;
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(CPU_IDLE_CYCLES);

  arbState_t               r_state, w_nextState;
  logic [1:0]              r_owner, w_nextOwner, w_winner;
  logic [IDLE_CNT_W-1:0]   r_idleCnt, w_idleNext, w_idleInc;
  logic [DROP_CNT_WIDTH-1:0] r_dropCnt;
  logic [DROP_SUM_W-1:0]   w_dropSum;
  logic [2:0]              w_dropInc;
  logic [DATA_WIDTH-1:0]   r_outData, w_outDataNext;
  logic                    r_outStrobe, w_outStrobeNext;

  // Per-source views indexed by owner code; slot 0 (NONE) never strobes.
  logic [3:0]              w_strb, w_keep;
  logic [DATA_WIDTH-1:0]   w_srcData [4];
  logic                    w_ownActive, w_preempt, w_release, w_flushDrop;

  logic                    w_pendLoad, w_pendFlush, w_pendValid;
  logic [DATA_WIDTH-1:0]   w_pendLoadData, w_pendData;

  assign w_strb       = {SelfWriteStrobe, BBWriteStrobe, UartWriteStrobe, 1'b0};
  assign w_srcData[0] = '0;
  assign w_srcData[1] = UartWriteData;
  assign w_srcData[2] = BBWriteData;
  assign w_srcData[3] = SelfWriteData;
  assign w_idleInc    = r_idleCnt + 1'b1;

  config_port_arbiter_pend #(.DATA_WIDTH(DATA_WIDTH)) u_pend (
    .clk        (CLK),
    .resetn     (resetn),
    .i_load     (w_pendLoad),
    .i_loadData (w_pendLoadData),
    .i_flush    (w_pendFlush),
    .o_valid    (w_pendValid),
    .o_data     (w_pendData)
  );

  // Fixed-priority winner among current requesters (UART > BB > CPU).
  always_comb begin
    w_winner = OWNER_NONE;
    if (UartActive)           w_winner = OWNER_UART;
    else if (BBActive)        w_winner = OWNER_BB;
    else if (SelfWriteStrobe) w_winner = OWNER_CPU;
  end

  // Owner's session request level, and the preempt / release conditions while owning.
  always_comb begin
    w_ownActive = 1'b0;
    if (r_owner == OWNER_UART)    w_ownActive = UartActive;
    else if (r_owner == OWNER_BB) w_ownActive = BBActive;
    w_preempt = (UartActive && (r_owner != OWNER_UART)) ||
                (BBActive && (r_owner == OWNER_CPU));
    if (r_owner == OWNER_CPU) w_release = !SelfWriteStrobe && (w_idleInc == IDLE_LIMIT);
    else                      w_release = !w_ownActive && !w_pendValid;
  end

  // Next state, ownership, pend control and output word for the coming cycle.
  always_comb begin
    w_nextState     = r_state;
    w_nextOwner     = r_owner;
    w_pendLoad      = 1'b0;
    w_pendLoadData  = w_srcData[r_owner];
    w_pendFlush     = 1'b0;
    w_keep          = '0;
    w_flushDrop     = 1'b0;
    w_outStrobeNext = 1'b0;
    w_outDataNext   = r_outData;
    w_idleNext      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_winner != OWNER_NONE) begin
          w_nextState = ST_SWITCH;
          w_nextOwner = w_winner;
          if (w_strb[w_winner]) begin
            w_pendLoad         = 1'b1;
            w_pendLoadData     = w_srcData[w_winner];
            w_keep[w_winner]   = 1'b1;
          end
        end
      end
      ST_SWITCH: begin
        w_nextState = ST_OWN;
        if (w_strb[r_owner] && !w_pendValid) begin
          w_pendLoad      = 1'b1;
          w_keep[r_owner] = 1'b1;
        end
      end
      ST_OWN: begin
        if (w_preempt) begin
          // Old session's buffered word is discarded; the newcomer's word is kept.
          w_nextState = ST_SWITCH;
          w_nextOwner = w_winner;
          w_pendFlush = 1'b1;
          w_flushDrop = w_pendValid;
          if (w_strb[w_winner]) begin
            w_pendLoad       = 1'b1;
            w_pendLoadData   = w_srcData[w_winner];
            w_keep[w_winner] = 1'b1;
          end
        end else begin
          if (w_pendValid) begin
            w_outStrobeNext = 1'b1;
            w_outDataNext   = w_pendData;
            if (w_strb[r_owner]) begin
              w_pendLoad      = 1'b1;
              w_keep[r_owner] = 1'b1;
            end else begin
              w_pendFlush = 1'b1;
            end
          end else if (w_strb[r_owner]) begin
            w_outStrobeNext = 1'b1;
            w_outDataNext   = w_srcData[r_owner];
            w_keep[r_owner] = 1'b1;
          end
          if (r_owner == OWNER_CPU) w_idleNext = SelfWriteStrobe ? '0 : w_idleInc;
          if (w_release) begin
            w_idleNext = '0;
            if (w_winner != OWNER_NONE) begin
              // A waiting lower source takes over directly: one handover pulse only.
              w_nextState = ST_SWITCH;
              w_nextOwner = w_winner;
              if (w_strb[w_winner]) begin
                w_pendLoad       = 1'b1;
                w_pendLoadData   = w_srcData[w_winner];
                w_keep[w_winner] = 1'b1;
              end
            end else begin
              w_nextState = ST_IDLE;
              w_nextOwner = OWNER_NONE;
            end
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextOwner = OWNER_NONE;
      end
    endcase
  end

  // Session state register: FSM state, current owner and CPU idle counter.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWNER_NONE;
      r_idleCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_owner   <= w_nextOwner;
      r_idleCnt <= w_idleNext;
    end
  end

  // Registered write port toward ConfigFSM; data holds between strobes.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_outStrobe <= 1'b0;
      r_outData   <= '0;
    end else begin
      r_outStrobe <= w_outStrobeNext;
      r_outData   <= w_outDataNext;
    end
  end

  assign w_dropInc = dropTally(w_strb & ~w_keep, w_flushDrop);
  assign w_dropSum = {3'b000, r_dropCnt} + {{DROP_CNT_WIDTH{1'b0}}, w_dropInc};

  // Saturating count of every strobe or buffered word that never reaches ConfigFSM.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_dropCnt <= '0;
    end else if (w_dropSum[DROP_SUM_W-1:DROP_CNT_WIDTH] != 3'b000) begin
      r_dropCnt <= '1;
    end else begin
      r_dropCnt <= w_dropSum[DROP_CNT_WIDTH-1:0];
    end
  end

  assign ConfigWriteData   = r_outData;
  assign ConfigWriteStrobe = r_outStrobe;
  assign FSM_Reset         = (r_state == ST_SWITCH);
  assign Owner             = r_owner;
  assign Busy              = (r_owner != OWNER_NONE);
  assign DropCount         = r_dropCnt;

endmodule
`default_nettype wire

// File: tb/tb_config_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_config_port_arbiter                                           |
// | Bench for config_port_arbiter: directed sessions plus randomized traffic   |
// | against a queue-based session model; two instances differ in drop width.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_config_port_arbiter;

  localparam int DW   = 32;
  localparam int IDLE = 8;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic          UartActive = 1'b0, UartWriteStrobe = 1'b0;
  logic          BBActive = 1'b0, BBWriteStrobe = 1'b0, SelfWriteStrobe = 1'b0;
  logic [DW-1:0] UartWriteData = '0, BBWriteData = '0, SelfWriteData = '0;

  logic [DW-1:0] aData, bData;
  logic          aStb, bStb, aRst, bRst, aBusy, bBusy;
  logic [1:0]    aOwner, bOwner;
  logic [7:0]    aDrop;
  logic [1:0]    bDrop;

  int nChecks = 0;
  int nErrors = 0;

  always #5 CLK = ~CLK;

  config_port_arbiter #(.DATA_WIDTH(DW), .CPU_IDLE_CYCLES(IDLE), .DROP_CNT_WIDTH(8)) dutA (
    .CLK(CLK), .resetn(resetn),
    .UartActive(UartActive), .UartWriteData(UartWriteData), .UartWriteStrobe(UartWriteStrobe),
    .BBActive(BBActive), .BBWriteData(BBWriteData), .BBWriteStrobe(BBWriteStrobe),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .ConfigWriteData(aData), .ConfigWriteStrobe(aStb), .FSM_Reset(aRst),
    .Owner(aOwner), .Busy(aBusy), .DropCount(aDrop));

  config_port_arbiter #(.DATA_WIDTH(DW), .CPU_IDLE_CYCLES(IDLE), .DROP_CNT_WIDTH(2)) dutB (
    .CLK(CLK), .resetn(resetn),
    .UartActive(UartActive), .UartWriteData(UartWriteData), .UartWriteStrobe(UartWriteStrobe),
    .BBActive(BBActive), .BBWriteData(BBWriteData), .BBWriteStrobe(BBWriteStrobe),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .ConfigWriteData(bData), .ConfigWriteStrobe(bStb), .FSM_Reset(bRst),
    .Owner(bOwner), .Busy(bBusy), .DropCount(bDrop));

  // ---------------- session model ----------------
  int            mOwner;      // 0 none, 1 uart, 2 bb, 3 cpu (also priority rank)
  bit            mHandover;   // this cycle is the handover cycle of a new session
  logic [DW-1:0] mPend[$];
  int            mQuiet;      // CPU owner: cycles since its last word
  int            mDrops;      // unsaturated discard total
  logic [DW-1:0] mOutData;
  bit            mOutStb;

  task automatic modelReset();
    mOwner = 0; mHandover = 0; mPend.delete(); mQuiet = 0; mDrops = 0;
    mOutData = '0; mOutStb = 0;
  endtask

  task automatic modelStep();
    bit            s[4], r[4], used[4];
    logic [DW-1:0] d[4];
    int            want, lost;
    bit            hadPend, finished;
    s = '{1'b0, UartWriteStrobe, BBWriteStrobe, SelfWriteStrobe};
    r = '{1'b0, UartActive, BBActive, SelfWriteStrobe};
    d = '{'0, UartWriteData, BBWriteData, SelfWriteData};
    used = '{default: 1'b0};
    want = 0;
    for (int i = 3; i >= 1; i--) if (r[i]) want = i;
    lost = 0;
    mOutStb = 0;
    if (mOwner == 0) begin
      if (want != 0) begin
        mOwner = want; mHandover = 1;
        if (s[want]) begin mPend.push_back(d[want]); used[want] = 1; end
      end
    end else if (mHandover) begin
      mHandover = 0;
      if (s[mOwner] && mPend.size() == 0) begin mPend.push_back(d[mOwner]); used[mOwner] = 1; end
    end else if (want != 0 && want < mOwner) begin
      lost += mPend.size();
      mPend.delete();
      mOwner = want; mHandover = 1;
      if (s[want]) begin mPend.push_back(d[want]); used[want] = 1; end
    end else begin
      hadPend = (mPend.size() != 0);
      if (hadPend) begin mOutData = mPend.pop_front(); mOutStb = 1; end
      if (s[mOwner]) begin
        used[mOwner] = 1;
        if (hadPend) mPend.push_back(d[mOwner]);
        else begin mOutData = d[mOwner]; mOutStb = 1; end
      end
      if (mOwner == 3) mQuiet = s[3] ? 0 : mQuiet + 1;
      finished = (mOwner == 3) ? (mQuiet == IDLE) : (!r[mOwner] && !hadPend);
      if (finished) begin
        if (want != 0) begin
          mOwner = want; mHandover = 1;
          if (s[want]) begin mPend.push_back(d[want]); used[want] = 1; end
        end else begin
          mOwner = 0;
        end
      end
    end
    if (mOwner != 3 || mHandover) mQuiet = 0;
    for (int i = 1; i <= 3; i++) if (s[i] && !used[i]) lost++;
    mDrops += lost;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    int expA, expB;
    expA = (mDrops > 255) ? 255 : mDrops;
    expB = (mDrops > 3) ? 3 : mDrops;
    check("A.Owner", 32'(aOwner), 32'(mOwner));
    check("A.FSM_Reset", 32'(aRst), 32'(mHandover));
    check("A.Busy", 32'(aBusy), 32'(mOwner != 0));
    check("A.Strobe", 32'(aStb), 32'(mOutStb));
    check("A.Data", aData, mOutData);
    check("A.DropCount", 32'(aDrop), 32'(expA));
    check("B.Owner", 32'(bOwner), 32'(mOwner));
    check("B.Strobe", 32'(bStb), 32'(mOutStb));
    check("B.Data", bData, mOutData);
    check("B.DropCount", 32'(bDrop), 32'(expB));
  endtask

  // One clock: model consumes the inputs the DUT samples, then outputs are compared.
  task automatic tick();
    modelStep();
    @(posedge CLK);
    @(negedge CLK);
    compareAll();
  endtask

  task automatic quiet();
    UartActive = 0; UartWriteStrobe = 0; BBActive = 0; BBWriteStrobe = 0; SelfWriteStrobe = 0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    resetn = 0;
    quiet();
    modelReset();
    @(negedge CLK);
    compareAll();
    resetn = 1;
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic asyncReset();
    #2 resetn = 0;
    #1;
    check("async.Owner", 32'(aOwner), 32'd0);
    check("async.Strobe", 32'(aStb), 32'd0);
    check("async.Data", aData, 32'd0);
    check("async.FSM_Reset", 32'(aRst), 32'd0);
    check("async.Busy", 32'(aBusy), 32'd0);
    check("async.DropCount", 32'(aDrop), 32'd0);
    check("async.B.DropCount", 32'(bDrop), 32'd0);
    modelReset();
    @(negedge CLK);
    resetn = 1;
  endtask

  initial begin
    int cnt, cpuRate;
    modelReset();
    doReset();
    check("reset.Owner", 32'(aOwner), 32'd0);
    check("reset.Data", aData, 32'd0);

    // 1: UART request with word in the same cycle
    UartActive = 1; UartWriteStrobe = 1; UartWriteData = 32'hA5A5_0001;
    tick();
    check("t1.FSM_Reset", 32'(aRst), 32'd1);
    check("t1.Owner", 32'(aOwner), 32'd1);
    UartWriteStrobe = 0;
    tick();
    check("t1.FSM_Reset_once", 32'(aRst), 32'd0);
    tick();
    check("t1.Strobe", 32'(aStb), 32'd1);
    check("t1.Data", aData, 32'hA5A5_0001);
    tick();
    check("t1.Strobe_once", 32'(aStb), 32'd0);
    UartActive = 0;
    tick();
    check("t1.Released", 32'(aOwner), 32'd0);

    // 2: CPU session released after IDLE quiet cycles
    doReset();
    SelfWriteStrobe = 1; SelfWriteData = 32'h11;
    tick();
    check("t2.Owner", 32'(aOwner), 32'd3);
    SelfWriteStrobe = 0;
    tick();
    tick();
    check("t2.Data11", aData, 32'h11);
    SelfWriteStrobe = 1; SelfWriteData = 32'h22;
    tick();
    check("t2.Data22", aData, 32'h22);
    SelfWriteStrobe = 0;
    cnt = 0;
    while (aBusy && cnt < IDLE + 4) begin tick(); cnt++; end
    check("t2.ReleaseCycles", 32'(cnt), 32'(IDLE));

    // 3: UART preempts BB while a BB word is pending
    doReset();
    BBActive = 1; BBWriteStrobe = 1; BBWriteData = 32'hBBBB_0003;
    tick();
    BBWriteStrobe = 0;
    tick();
    UartActive = 1;
    tick();
    check("t3.FSM_Reset", 32'(aRst), 32'd1);
    check("t3.Owner", 32'(aOwner), 32'd1);
    check("t3.DropCount", 32'(aDrop), 32'd1);
    tick();
    check("t3.NoBBWord", 32'(aStb), 32'd0);
    tick();
    check("t3.NoBBWord2", 32'(aStb), 32'd0);

    // 4/6: non-owner strobes dropped; 2-bit counter saturates
    doReset();
    UartActive = 1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      BBWriteStrobe = 1; SelfWriteStrobe = (i < 2); BBWriteData = 32'(i); SelfWriteData = 32'(i);
      tick();
      check("t4.NoFSM_Reset", 32'(aRst), 32'd0);
      check("t4.NoStrobe", 32'(aStb), 32'd0);
    end
    BBWriteStrobe = 0; SelfWriteStrobe = 0;
    check("t4.DropCount", 32'(aDrop), 32'd5);
    check("t6.DropCountSat", 32'(bDrop), 32'd3);

    // 5: back-to-back UART words
    doReset();
    UartActive = 1;
    tick(); tick();
    for (int i = 1; i <= 8; i++) begin
      UartWriteStrobe = 1; UartWriteData = 32'(i);
      tick();
      check("t5.Strobe", 32'(aStb), 32'd1);
      check("t5.Data", aData, 32'(i));
    end
    UartWriteStrobe = 0;
    tick();
    check("t5.End", 32'(aStb), 32'd0);

    // 6: reset in the middle of a session with a word pending
    doReset();
    UartActive = 1; UartWriteStrobe = 1; UartWriteData = 32'hDEAD_0006;
    tick();
    UartWriteStrobe = 0;
    tick();
    asyncReset();
    quiet();
    tick();
    check("t6.NoStrobeAfterReset", 32'(aStb), 32'd0);

    // Randomized traffic
    doReset();
    cpuRate = 6;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 100 == 0) cpuRate = $urandom_range(1, 14);
      if ($urandom % 16 == 0) UartActive = ~UartActive;
      if ($urandom % 12 == 0) BBActive = ~BBActive;
      UartWriteStrobe = UartActive ? 1'($urandom % 2) : 1'($urandom % 10 == 0);
      BBWriteStrobe   = BBActive ? 1'($urandom % 2) : 1'($urandom % 10 == 0);
      SelfWriteStrobe = 1'($urandom % cpuRate == 0);
      UartWriteData = $urandom; BBWriteData = $urandom; SelfWriteData = $urandom;
      tick();
      if ($urandom % 500 == 0) asyncReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
